// File: rtl/hpm_event_select.sv
// mhpmevent3..mhpmevent(COUNTERS-1) CSR bank: per-counter event select, privilege inhibit,
// registered increment requests, and sticky overflow bits with a local overflow interrupt pulse.
module hpm_event_select #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned COUNTERS   = 32,
  parameter int unsigned NUM_EVENTS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  CSRMWriteM,
  input  logic [11:0]           CSRAdrM,
  input  logic [XLEN-1:0]       CSRWriteValM,
  input  logic [1:0]            PrivilegeModeW,
  input  logic [NUM_EVENTS-1:0] EventSrcM,
  input  logic [COUNTERS-1:0]   CounterOverflowM,
  output logic [COUNTERS-1:0]   CounterEventM,
  output logic [XLEN-1:0]       MHPMEVENTReadValM,
  output logic                  MHPMEVENTHitM,
  output logic [COUNTERS-1:0]   OverflowVecM,
  output logic                  LCOFIRequestM
);

  localparam bit IsRv32 = (XLEN == 32);

  logic [COUNTERS-1:0] r_of, r_minh, r_sinh, r_uinh, r_cev;
  logic [7:0]          r_evsel [COUNTERS];
  logic                r_lcofi;

  logic [COUNTERS-1:0] w_sel, w_impl, w_of_base, w_cev_d, w_src, w_inh;
  logic                w_blk_lo, w_blk_hi, w_hit_lo, w_hit_hi;
  logic                w_we_lo, w_flags_we, w_lcofi_d;
  logic [3:0]          w_new_flags, w_rd_flags;
  logic [7:0]          w_new_evsel, w_rd_evsel;
  logic                w_unused;

  assign w_blk_lo = (CSRAdrM[11:5] == 7'h19);
  assign w_blk_hi = IsRv32 && (CSRAdrM[11:5] == 7'h39);

  always_comb begin
    w_sel  = '0;
    w_impl = '0;
    for (int i = 3; i < int'(COUNTERS); i++) begin
      w_impl[i] = 1'b1;
      w_sel[i]  = (CSRAdrM[4:0] == 5'(i));
    end
  end

  assign w_hit_lo      = w_blk_lo & (|w_sel);
  assign w_hit_hi      = w_blk_hi & (|w_sel);
  assign MHPMEVENTHitM = w_hit_lo | w_hit_hi;

  // On RV32 the OF/xINH flags live only in mhpmeventh.
  assign w_we_lo     = CSRMWriteM & w_hit_lo;
  assign w_flags_we  = CSRMWriteM & (IsRv32 ? w_hit_hi : w_hit_lo);
  assign w_new_flags = CSRWriteValM[XLEN-1 -: 4];
  assign w_new_evsel = (32'(CSRWriteValM[7:0]) < NUM_EVENTS) ? CSRWriteValM[7:0] : 8'd0;

  // A simultaneous overflow wins over a clearing write, and still raises the request.
  always_comb begin
    w_of_base = r_of;
    if (w_flags_we) begin
      w_of_base = (r_of & ~w_sel) | (w_sel & {COUNTERS{w_new_flags[3]}});
    end
  end

  assign w_lcofi_d = |(CounterOverflowM & w_impl & ~w_of_base);

  always_comb begin
    w_src   = '0;
    w_inh   = '0;
    w_cev_d = '0;
    for (int i = 3; i < int'(COUNTERS); i++) begin
      for (int j = 1; j < int'(NUM_EVENTS); j++) begin
        if (r_evsel[i] == 8'(j)) w_src[i] = EventSrcM[j];
      end
      case (PrivilegeModeW)
        2'd0:    w_inh[i] = r_uinh[i];
        2'd1:    w_inh[i] = r_sinh[i];
        default: w_inh[i] = r_minh[i];
      endcase
      w_cev_d[i] = w_src[i] & ~w_inh[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_of    <= '0;
      r_minh  <= '0;
      r_sinh  <= '0;
      r_uinh  <= '0;
      r_cev   <= '0;
      r_lcofi <= 1'b0;
      for (int i = 0; i < int'(COUNTERS); i++) r_evsel[i] <= '0;
    end else begin
      r_of    <= w_of_base | (CounterOverflowM & w_impl);
      r_cev   <= w_cev_d;
      r_lcofi <= w_lcofi_d;
      for (int i = 3; i < int'(COUNTERS); i++) begin
        if (w_we_lo && w_sel[i]) r_evsel[i] <= w_new_evsel;
        if (w_flags_we && w_sel[i]) begin
          r_minh[i] <= w_new_flags[2];
          r_sinh[i] <= w_new_flags[1];
          r_uinh[i] <= w_new_flags[0];
        end
      end
    end
  end

  always_comb begin
    MHPMEVENTReadValM = '0;
    w_rd_flags        = '0;
    w_rd_evsel        = '0;
    for (int i = 3; i < int'(COUNTERS); i++) begin
      if (w_sel[i]) begin
        w_rd_flags = {r_of[i], r_minh[i], r_sinh[i], r_uinh[i]};
        w_rd_evsel = r_evsel[i];
      end
    end
    if (w_hit_lo) begin
      MHPMEVENTReadValM[7:0] = w_rd_evsel;
      if (!IsRv32) MHPMEVENTReadValM[XLEN-1 -: 4] = w_rd_flags;
    end else if (w_hit_hi) begin
      MHPMEVENTReadValM[XLEN-1 -: 4] = w_rd_flags;
    end
  end

  assign CounterEventM = r_cev;
  assign OverflowVecM  = r_of;
  assign LCOFIRequestM = r_lcofi;

  assign w_unused = ^{EventSrcM[0], CSRWriteValM};

endmodule

// File: tb/tb_hpm_event_select.sv
// Randomised and directed checks of hpm_event_select (RV64 and RV32 instances) against a
// behavioural CSR/event model.
module tb_hpm_event_select;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we = 1'b0;
  logic [11:0] adr = '0;
  logic [63:0] wval = '0;
  logic [1:0]  priv = 2'd3;
  logic [31:0] ev = '0;
  logic [31:0] ovf = '0;
  logic [31:0] cev64, ovec64;
  logic [63:0] rd64;
  logic        hit64, lcofi64;

  logic        we32 = 1'b0;
  logic [11:0] adr32 = '0;
  logic [31:0] wval32 = '0;
  logic [31:0] cev32, ovec32, rd32;
  logic        hit32, lcofi32;

  int total = 0;
  int bad = 0;

  // model state
  int          m_evsel [32];
  logic [31:0] m_of, m_minh, m_sinh, m_uinh;
  logic [31:0] m_cev;
  logic        m_lcofi;

  always #5 clk = ~clk;

  hpm_event_select #(.XLEN(64), .COUNTERS(32), .NUM_EVENTS(32)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .CSRMWriteM(we), .CSRAdrM(adr), .CSRWriteValM(wval),
    .PrivilegeModeW(priv), .EventSrcM(ev), .CounterOverflowM(ovf), .CounterEventM(cev64),
    .MHPMEVENTReadValM(rd64), .MHPMEVENTHitM(hit64), .OverflowVecM(ovec64),
    .LCOFIRequestM(lcofi64)
  );

  hpm_event_select #(.XLEN(32), .COUNTERS(32), .NUM_EVENTS(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .CSRMWriteM(we32), .CSRAdrM(adr32), .CSRWriteValM(wval32),
    .PrivilegeModeW(priv), .EventSrcM(ev), .CounterOverflowM(ovf), .CounterEventM(cev32),
    .MHPMEVENTReadValM(rd32), .MHPMEVENTHitM(hit32), .OverflowVecM(ovec32),
    .LCOFIRequestM(lcofi32)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_evsel[i] = 0;
    m_of = '0; m_minh = '0; m_sinh = '0; m_uinh = '0; m_cev = '0; m_lcofi = 1'b0;
  endtask

  function automatic bit in_bank(input logic [11:0] a);
    return (a >= 12'h323) && (a <= 12'h33F);
  endfunction

  function automatic logic [63:0] mread(input logic [11:0] a);
    int i;
    if (!in_bank(a)) return 64'd0;
    i = int'(a) - 'h320;
    return ({63'd0, m_of[i]} << 63) | ({63'd0, m_minh[i]} << 62) | ({63'd0, m_sinh[i]} << 61)
         | ({63'd0, m_uinh[i]} << 60) | 64'(m_evsel[i]);
  endfunction

  // One clock: predict from pre-edge config and inputs, then apply write and overflow.
  task automatic cycle();
    logic [31:0] exp_cev;
    logic        pulse;
    bit          inh;
    int          k;
    exp_cev = '0;
    for (int i = 3; i < 32; i++) begin
      inh = (priv == 2'd0) ? m_uinh[i] : (priv == 2'd1) ? m_sinh[i] : m_minh[i];
      if (m_evsel[i] != 0 && ev[m_evsel[i]] && !inh) exp_cev[i] = 1'b1;
    end
    if (we && in_bank(adr)) begin
      k = int'(adr) - 'h320;
      m_evsel[k] = (wval[7:0] < 8'd32) ? int'(wval[7:0]) : 0;
      m_of[k] = wval[63]; m_minh[k] = wval[62]; m_sinh[k] = wval[61]; m_uinh[k] = wval[60];
    end
    pulse = 1'b0;
    for (int i = 3; i < 32; i++) begin
      if (ovf[i] && !m_of[i]) pulse = 1'b1;
      if (ovf[i]) m_of[i] = 1'b1;
    end
    @(posedge clk);
    #1;
    m_cev = exp_cev;
    m_lcofi = pulse;
  endtask

  task automatic test_reset();
    total++;
    if (cev64 !== 32'd0 || ovec64 !== 32'd0 || lcofi64 !== 1'b0) begin
      bad++; $display("FAIL reset_initial: cev=%h of=%h lcofi=%b required 0", cev64, ovec64, lcofi64);
    end
    @(negedge clk); reset_n = 1'b1; model_reset();
    we = 1'b1; adr = 12'h323; wval = 64'd5; cycle();
    we = 1'b0; ev = 32'h20; ovf = 32'h10; cycle();
    ovf = '0; cycle();
    total++;
    if (rd64 !== 64'd5 || cev64 !== m_cev || ovec64 !== m_of) begin
      bad++; $display("FAIL reset_prefill: rd=%h cev=%h of=%h required 5 %h %h",
                      rd64, cev64, ovec64, m_cev, m_of);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (cev64 !== 32'd0 || ovec64 !== 32'd0 || lcofi64 !== 1'b0 || rd64 !== 64'd0
        || cev32 !== 32'd0 || ovec32 !== 32'd0) begin
      bad++; $display("FAIL reset_async: cev=%h of=%h lcofi=%b rd=%h cev32=%h required 0",
                      cev64, ovec64, lcofi64, rd64, cev32);
    end
    ev = '0;
    @(negedge clk); reset_n = 1'b1; model_reset();
  endtask

  task automatic test_event_select();
    we = 1'b1; adr = 12'h324; wval = 64'd7; priv = 2'd3; cycle();
    we = 1'b0; cycle();
    ev = 32'h80; cycle();
    total++;
    if (cev64 !== 32'h10 || cev64 !== m_cev) begin
      bad++; $display("FAIL evsel_hit: cev=%h required %h", cev64, 32'h10);
    end
    ev = '0; cycle();
    total++;
    if (cev64 !== 32'd0) begin
      bad++; $display("FAIL evsel_oneshot: cev=%h required 0", cev64);
    end
  endtask

  task automatic test_warl();
    we = 1'b1; adr = 12'h325; wval = 64'd40; cycle();
    we = 1'b0;
    total++;
    if (rd64 !== 64'd0 || rd64 !== mread(adr)) begin
      bad++; $display("FAIL warl_read: rd=%h required 0", rd64);
    end
    ev = 32'hFFFF_FFFF; cycle();
    total++;
    if (cev64[5] !== 1'b0 || cev64 !== m_cev) begin
      bad++; $display("FAIL warl_event: cev=%h required %h", cev64, m_cev);
    end
    ev = '0; cycle();
  endtask

  task automatic test_inhibit();
    we = 1'b1; adr = 12'h326; wval = 64'h1000_0000_0000_0002; cycle();
    we = 1'b0; ev = 32'h4; priv = 2'd0; cycle(); cycle();
    total++;
    if (cev64[6] !== 1'b0 || cev64 !== m_cev) begin
      bad++; $display("FAIL inh_umode: cev=%h required %h", cev64, m_cev);
    end
    priv = 2'd1; cycle();
    total++;
    if (cev64[6] !== 1'b1 || cev64 !== m_cev) begin
      bad++; $display("FAIL inh_smode: cev=%h required %h", cev64, m_cev);
    end
    ev = '0; priv = 2'd3; cycle();
  endtask

  task automatic test_overflow();
    ovf = 32'h208; cycle();
    ovf = '0;
    total++;
    if (ovec64 !== 32'h208 || lcofi64 !== 1'b1 || lcofi64 !== m_lcofi) begin
      bad++; $display("FAIL ovf_set: of=%h lcofi=%b required 208 1", ovec64, lcofi64);
    end
    cycle();
    total++;
    if (lcofi64 !== 1'b0) begin
      bad++; $display("FAIL ovf_single_pulse: lcofi=%b required 0", lcofi64);
    end
    ovf = 32'h8; cycle();
    ovf = '0;
    total++;
    if (lcofi64 !== 1'b0 || ovec64 !== 32'h208) begin
      bad++; $display("FAIL ovf_repeat: lcofi=%b of=%h required 0 208", lcofi64, ovec64);
    end
  endtask

  task automatic test_collision();
    we = 1'b1; adr = 12'h323; wval = 64'd5; ovf = 32'h8; cycle();
    we = 1'b0; ovf = '0;
    total++;
    if (rd64[63] !== 1'b1 || lcofi64 !== 1'b1 || rd64 !== mread(adr) || lcofi64 !== m_lcofi) begin
      bad++; $display("FAIL collision: rd=%h lcofi=%b required %h 1", rd64, lcofi64, mread(adr));
    end
  endtask

  task automatic test_rv32();
    we32 = 1'b1; adr32 = 12'h727; wval32 = 32'h4000_0000; cycle();
    adr32 = 12'h327; wval32 = 32'h1; cycle();
    we32 = 1'b0; adr32 = 12'h727; #1;
    total++;
    if (rd32 !== 32'h4000_0000 || hit32 !== 1'b1) begin
      bad++; $display("FAIL rv32_hi_read: rd=%h hit=%b required 40000000 1", rd32, hit32);
    end
    adr32 = 12'h327; #1;
    total++;
    if (rd32 !== 32'h1 || hit32 !== 1'b1) begin
      bad++; $display("FAIL rv32_lo_read: rd=%h hit=%b required 1 1", rd32, hit32);
    end
    adr = 12'h727; #1;
    total++;
    if (hit64 !== 1'b0 || rd64 !== 64'd0) begin
      bad++; $display("FAIL rv64_no_h: hit=%b rd=%h required 0 0", hit64, rd64);
    end
    priv = 2'd3; ev = 32'h2; cycle();
    total++;
    if (cev32 !== 32'd0) begin
      bad++; $display("FAIL rv32_minh: cev=%h required 0", cev32);
    end
    priv = 2'd0; cycle();
    total++;
    if (cev32 !== 32'h80) begin
      bad++; $display("FAIL rv32_umode: cev=%h required 80", cev32);
    end
    ev = '0; priv = 2'd3; cycle();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      priv = 2'($urandom_range(0, 3));
      ev   = $urandom();
      ovf  = $urandom() & $urandom() & $urandom() & $urandom();
      we   = ($urandom_range(0, 3) == 0);
      adr  = ($urandom_range(0, 7) == 0) ? 12'(12'h720 + $urandom_range(0, 31))
                                         : 12'(12'h31E + $urandom_range(0, 35));
      wval = {$urandom(), $urandom()};
      wval[7:0] = 8'($urandom_range(0, 63));
      cycle();
      total++;
      if (cev64 !== m_cev || ovec64 !== m_of || lcofi64 !== m_lcofi
          || rd64 !== mread(adr) || hit64 !== in_bank(adr)) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL random[%0d]: cev=%h/%h of=%h/%h lcofi=%b/%b rd=%h/%h hit=%b/%b", n,
                   cev64, m_cev, ovec64, m_of, lcofi64, m_lcofi, rd64, mread(adr), hit64,
                   in_bank(adr));
      end
    end
    we = 1'b0; ev = '0; ovf = '0;
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_event_select();
    test_warl();
    test_inhibit();
    test_overflow();
    test_collision();
    test_rv32();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
